// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: instruction-sequencing FSM, ALU decoder and
// conditional-execution logic with the NZCV flag register.
module arm_mc_controller #(
  parameter int unsigned ALUC_W  = 3,
  parameter bit          EXT_OPS = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        Cond,
  input  logic [1:0]        Op,
  input  logic [5:0]        Funct,
  input  logic [3:0]        Rd,
  input  logic [3:0]        ALUFlags,
  output logic              IRWrite,
  output logic              AdrSrc,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ResultSrc,
  output logic [1:0]        ImmSrc,
  output logic [1:0]        RegSrc,
  output logic [ALUC_W-1:0] ALUControl,
  output logic              PCWrite,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic [3:0]        Flags,
  output logic              Illegal
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECR, EXECI, ALUWB, BRANCH, UNKNOWN
  } state_t;

  state_t     state;
  logic       cond_q;
  logic       cond_ex;
  logic [2:0] alu_op;
  logic       no_write;
  logic       upd_cv;
  logic       supported;
  logic       ir_w, pc_w, reg_w, mem_w;

  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = Flags;

  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = !flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = !flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = !flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = !flag_v;
      4'b1000: cond_ex = flag_c && !flag_z;
      4'b1001: cond_ex = !flag_c || flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = !flag_z && (flag_n == flag_v);
      4'b1101: cond_ex = flag_z || (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Unsupported encodings fall through as ADD with no register or flag write.
  always_comb begin
    alu_op    = 3'd0;
    no_write  = 1'b1;
    upd_cv    = 1'b0;
    supported = 1'b0;
    case (Funct[4:1])
      4'b0100: begin alu_op = 3'd0; no_write = 1'b0; upd_cv = 1'b1; supported = 1'b1; end
      4'b0010: begin alu_op = 3'd1; no_write = 1'b0; upd_cv = 1'b1; supported = 1'b1; end
      4'b0000: begin alu_op = 3'd2; no_write = 1'b0; supported = 1'b1; end
      4'b1100: begin alu_op = 3'd3; no_write = 1'b0; supported = 1'b1; end
      4'b0001: if (EXT_OPS) begin alu_op = 3'd4; no_write = 1'b0; supported = 1'b1; end
      4'b1010: if (EXT_OPS && Funct[0]) begin alu_op = 3'd1; upd_cv = 1'b1; supported = 1'b1; end
      4'b1000: if (EXT_OPS && Funct[0]) begin alu_op = 3'd2; supported = 1'b1; end
      4'b1101: if (EXT_OPS) begin alu_op = 3'd5; no_write = 1'b0; supported = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= FETCH;
      Flags  <= '0;
      cond_q <= 1'b0;
    end else begin
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          cond_q <= cond_ex;
          case (Op)
            2'b00:   state <= Funct[5] ? EXECI : EXECR;
            2'b01:   state <= MEMADR;
            2'b10:   state <= BRANCH;
            default: state <= UNKNOWN;
          endcase
        end
        MEMADR: state <= Funct[0] ? MEMRD : MEMWR;
        MEMRD:  state <= MEMWB;
        EXECR, EXECI: begin
          state <= ALUWB;
          if (cond_q && Funct[0] && supported) begin
            Flags[3:2] <= ALUFlags[3:2];
            if (upd_cv) Flags[1:0] <= ALUFlags[1:0];
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Moore decode of the current state; write enables are also gated by
  // reset_n so they fall the moment reset is asserted.
  always_comb begin
    ir_w       = 1'b0;
    pc_w       = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = '0;
    Illegal    = 1'b0;
    case (state)
      FETCH: begin
        ir_w = 1'b1; pc_w = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = cond_q;
        pc_w      = cond_q && (Rd == 4'b1111);
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = cond_q;
      end
      EXECR: ALUControl = ALUC_W'(alu_op);
      EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = ALUC_W'(alu_op);
      end
      ALUWB: begin
        reg_w = cond_q && !no_write;
        pc_w  = cond_q && !no_write && (Rd == 4'b1111);
      end
      BRANCH: begin
        ALUSrcB = 2'b01; ResultSrc = 2'b10; pc_w = cond_q;
      end
      UNKNOWN: Illegal = 1'b1;
      default: ;
    endcase
  end

  assign IRWrite  = ir_w  && reset_n;
  assign PCWrite  = pc_w  && reset_n;
  assign RegWrite = reg_w && reset_n;
  assign MemWrite = mem_w && reset_n;
  assign ImmSrc   = Op;
  assign RegSrc   = {Op == 2'b01, Op == 2'b10};

endmodule

// File: tb/tb_arm_mc_controller.sv
// Bench for arm_mc_controller: per-instruction expected cycle traces built from
// the instruction-level rules, checked every cycle, plus literal anchor checks.
module tb_arm_mc_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;

  logic       IRWrite, AdrSrc, ALUSrcA, PCWrite, RegWrite, MemWrite, Illegal;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [2:0] ALUControl;
  logic [3:0] Flags;

  logic       IRWrite0, AdrSrc0, ALUSrcA0, PCWrite0, RegWrite0, MemWrite0, Illegal0;
  logic [1:0] ALUSrcB0, ResultSrc0, ImmSrc0, RegSrc0, ALUControl0;
  logic [3:0] Flags0;

  arm_mc_controller #(.ALUC_W(3), .EXT_OPS(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .Flags(Flags), .Illegal(Illegal));

  arm_mc_controller #(.ALUC_W(2), .EXT_OPS(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .IRWrite(IRWrite0), .AdrSrc(AdrSrc0), .ALUSrcA(ALUSrcA0),
    .ALUSrcB(ALUSrcB0), .ResultSrc(ResultSrc0), .ImmSrc(ImmSrc0), .RegSrc(RegSrc0),
    .ALUControl(ALUControl0), .PCWrite(PCWrite0), .RegWrite(RegWrite0),
    .MemWrite(MemWrite0), .Flags(Flags0), .Illegal(Illegal0));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       irw;
    logic       adr;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic [1:0] imm;
    logic [1:0] rsrc;
    logic [2:0] ctl;
    logic       pcw;
    logic       rw;
    logic       mw;
    logic [3:0] flags;
    logic       ill;
  } rec_t;

  rec_t       expq[$];
  int         checks   = 0;
  int         failures = 0;
  logic [3:0] mflags   = 4'b0000;
  int         sidx     = 0;
  logic       seen_pcw[8], seen_rw[8], seen_mw[8], seen_ill[8], seen_rw0[8];
  logic [1:0] seen_res[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ARM condition: base test chosen by Cond[3:1], inverted by Cond[0].
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy & ~z;
      3'd5: r = (n == v);
      3'd6: r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    return c[0] ? ~r : r;
  endfunction

  function automatic rec_t base(input logic [1:0] o, input logic [3:0] f);
    rec_t r = '0;
    r.imm   = o;
    r.rsrc  = {o == 2'b01, o == 2'b10};
    r.flags = f;
    return r;
  endfunction

  task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] d, input logic [3:0] af, input int max_cycles);
    rec_t  q[$];
    rec_t  r;
    logic  ce, sup, wr, cv;
    logic [2:0] op3;
    logic [3:0] nf;
    int    n;
    Cond = c; Op = o; Funct = f; Rd = d; ALUFlags = af;
    ce = cond_ok(c, mflags);
    r = base(o, mflags); r.irw = 1; r.pcw = 1; r.srca = 1; r.srcb = 2'b10; r.res = 2'b10; q.push_back(r);
    r = base(o, mflags); r.srca = 1; r.srcb = 2'b10; r.res = 2'b10; q.push_back(r);
    case (o)
      2'b00: begin
        sup = 1; wr = 1; cv = 0; op3 = 3'd0;
        case (f[4:1])
          4'b0100: cv = 1;
          4'b0010: begin op3 = 3'd1; cv = 1; end
          4'b0000: op3 = 3'd2;
          4'b1100: op3 = 3'd3;
          4'b0001: op3 = 3'd4;
          4'b1101: op3 = 3'd5;
          4'b1010: begin op3 = 3'd1; cv = 1; wr = 0; sup = f[0]; end
          4'b1000: begin op3 = 3'd2; wr = 0; sup = f[0]; end
          default: sup = 0;
        endcase
        if (!sup) begin op3 = 3'd0; wr = 0; end
        nf = mflags;
        if (ce && f[0] && sup) begin
          nf[3:2] = af[3:2];
          if (cv) nf[1:0] = af[1:0];
        end
        r = base(o, mflags); r.srcb = f[5] ? 2'b01 : 2'b00; r.ctl = op3; q.push_back(r);
        mflags = nf;
        r = base(o, mflags); r.rw = ce & wr; r.pcw = ce & wr & (d == 4'hF); q.push_back(r);
      end
      2'b01: begin
        r = base(o, mflags); r.srcb = 2'b01; q.push_back(r);
        if (f[0]) begin
          r = base(o, mflags); r.adr = 1; q.push_back(r);
          r = base(o, mflags); r.res = 2'b01; r.rw = ce; r.pcw = ce & (d == 4'hF); q.push_back(r);
        end else begin
          r = base(o, mflags); r.adr = 1; r.mw = ce; q.push_back(r);
        end
      end
      2'b10: begin
        r = base(o, mflags); r.srcb = 2'b01; r.res = 2'b10; r.pcw = ce; q.push_back(r);
      end
      default: begin
        r = base(o, mflags); r.ill = 1; q.push_back(r);
      end
    endcase
    n = (max_cycles > 0 && max_cycles < q.size()) ? max_cycles : q.size();
    sidx = 0;
    for (int i = 0; i < n; i++) expq.push_back(q[i]);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    rec_t e, a;
    if (reset_n && expq.size() > 0) begin
      e = expq.pop_front();
      a = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl,
           PCWrite, RegWrite, MemWrite, Flags, Illegal};
      chk($sformatf("cycle%0d", sidx), 32'(a), 32'(e));
      if (sidx < 8) begin
        seen_pcw[sidx] = PCWrite;  seen_rw[sidx]  = RegWrite; seen_mw[sidx] = MemWrite;
        seen_ill[sidx] = Illegal;  seen_res[sidx] = ResultSrc; seen_rw0[sidx] = RegWrite0;
      end
      sidx++;
    end
  end

  initial begin
    logic [3:0] f0;
    reset_n = 0; Cond = 0; Op = 0; Funct = 0; Rd = 0; ALUFlags = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", 32'(Flags), 32'h0);
    chk("rst_pcwrite", 32'(PCWrite), 32'h0);
    chk("rst_irwrite", 32'(IRWrite), 32'h0);
    reset_n = 1;

    // SUBS R1,R2,#1
    run_instr(4'hE, 2'b00, 6'b100101, 4'h1, 4'b0110, 0);
    chk("subs_len", 32'(sidx), 32'd4);
    chk("subs_flags", 32'(Flags), 32'h6);
    chk("subs_rw", 32'(seen_rw[3]), 32'h1);
    // CMP Z=1 then BEQ taken
    run_instr(4'hE, 2'b00, 6'b010101, 4'h0, 4'b0100, 0);
    chk("cmp_z1_flags", 32'(Flags), 32'h4);
    chk("cmp_nowrite", 32'(seen_rw[3]), 32'h0);
    run_instr(4'h0, 2'b10, 6'b000000, 4'h0, 4'b0000, 0);
    chk("beq_len", 32'(sidx), 32'd3);
    chk("beq_taken", 32'(seen_pcw[2]), 32'h1);
    // CMP Z=0 then BEQ not taken
    run_instr(4'hE, 2'b00, 6'b010101, 4'h0, 4'b0000, 0);
    run_instr(4'h0, 2'b10, 6'b000000, 4'h0, 4'b0000, 0);
    chk("beq_not_taken", 32'(seen_pcw[2]), 32'h0);
    // LDR R15
    run_instr(4'hE, 2'b01, 6'b000001, 4'hF, 4'b0000, 0);
    chk("ldr_len", 32'(sidx), 32'd5);
    chk("ldr_res", 32'(seen_res[4]), 32'h1);
    chk("ldr_rw", 32'(seen_rw[4]), 32'h1);
    chk("ldr_pcw", 32'(seen_pcw[4]), 32'h1);
    // STRNE with Z=1
    run_instr(4'hE, 2'b00, 6'b010101, 4'h0, 4'b0100, 0);
    run_instr(4'h1, 2'b01, 6'b000000, 4'h2, 4'b0000, 0);
    chk("strne_len", 32'(sidx), 32'd4);
    chk("strne_mw", 32'(seen_mw[3]), 32'h0);
    // LDRNE with Z=0
    run_instr(4'hE, 2'b00, 6'b010101, 4'h0, 4'b0000, 0);
    run_instr(4'h1, 2'b01, 6'b000001, 4'h3, 4'b0000, 0);
    chk("ldrne_mw", 32'({seen_mw[0], seen_mw[1], seen_mw[2], seen_mw[3], seen_mw[4]}), 32'h0);
    chk("ldrne_rw", 32'(seen_rw[4]), 32'h1);
    chk("ldrne_pcw", 32'(seen_pcw[4]), 32'h0);
    // Illegal opcode
    run_instr(4'hE, 2'b11, 6'b000000, 4'hF, 4'b0000, 0);
    chk("ill_len", 32'(sidx), 32'd3);
    chk("ill_flag", 32'(seen_ill[2]), 32'h1);
    chk("ill_writes", 32'({seen_rw[2], seen_pcw[2], seen_mw[2]}), 32'h0);
    // EORS: executes with EXT_OPS=1, suppressed with EXT_OPS=0
    f0 = Flags0;
    run_instr(4'hE, 2'b00, 6'b000011, 4'h2, 4'b1011, 0);
    chk("eor_flags", 32'(Flags), 32'h8);
    chk("eor_rw", 32'(seen_rw[3]), 32'h1);
    chk("eor_ext0_rw", 32'(seen_rw0[3]), 32'h0);
    chk("eor_ext0_flags", 32'(Flags0), 32'(f0));
    // ADDSGT failing (N=1,V=0), MOV imm, TST without S
    run_instr(4'hC, 2'b00, 6'b101001, 4'h5, 4'b0111, 0);
    chk("addsgt_flags", 32'(Flags), 32'h8);
    chk("addsgt_rw", 32'(seen_rw[3]), 32'h0);
    run_instr(4'hE, 2'b00, 6'b111010, 4'h4, 4'b0000, 0);
    run_instr(4'hE, 2'b00, 6'b010000, 4'h4, 4'b0101, 0);
    chk("tst_nos_rw", 32'(seen_rw[3]), 32'h0);

    // Reset asserted during MEMWR of an STR
    run_instr(4'hE, 2'b01, 6'b000000, 4'h1, 4'b0000, 3);
    chk("memwr_pre_rst", 32'(MemWrite), 32'h1);
    #2 reset_n = 0;
    #1;
    chk("memwr_rst_mw", 32'(MemWrite), 32'h0);
    chk("memwr_rst_flags", 32'(Flags), 32'h0);
    mflags = 4'b0000;
    @(posedge clk);
    #1 reset_n = 1;
    #1;
    chk("rel_pcwrite", 32'(PCWrite), 32'h1);
    chk("rel_irwrite", 32'(IRWrite), 32'h1);
    // ADDS register form after restart
    run_instr(4'hE, 2'b00, 6'b001001, 4'h6, 4'b0011, 0);
    chk("adds_flags", 32'(Flags), 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
